// File: rtl/temp_acq_ctrl.sv
// Measurement-cycle controller: scans the sensor bank, sums the enabled readings,
// then drives the shared divider and holds the average for the display/alert stage.
module temp_acq_ctrl #(
  parameter int unsigned SENSOR_NR   = 8,
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [SENSOR_NR-1:0] sensor_en_i,
  output logic [2:0]           sensor_sel_o,
  input  logic [7:0]           sensor_data_i,
  output logic                 div_start_o,
  output logic [15:0]          div_dividend_o,
  output logic [7:0]           div_divisor_o,
  input  logic                 div_done_i,
  input  logic [15:0]          div_q_i,
  input  logic [15:0]          div_r_i,
  output logic [15:0]          temp_Q_o,
  output logic [15:0]          temp_R_o,
  output logic [7:0]           active_sensors_nr_o,
  output logic                 result_valid_o,
  output logic                 busy_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DIV_REQ,
    ST_DIV_WAIT
  } state_t;

  localparam int unsigned   TW       = $clog2(DIV_TIMEOUT) + 1;
  localparam logic [2:0]    LAST_IDX = 3'(SENSOR_NR - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DIV_TIMEOUT - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SENSOR_NR-1:0] r_mask;
  logic [15:0]          r_sum;
  logic [7:0]           r_cnt;
  logic [2:0]           r_idx;
  logic [TW-1:0]        r_tmo;
  logic [15:0]          r_q;
  logic [15:0]          r_r;
  logic [7:0]           r_nr;
  logic                 r_valid;
  logic                 r_err;

  logic [7:0]           w_mask_ext;
  logic                 w_hit;
  logic                 w_last;
  logic                 w_tmo_exp;
  logic [7:0]           w_cnt_scan;
  logic                 w_err_nxt;

  assign w_mask_ext = 8'(r_mask);
  assign w_hit      = w_mask_ext[r_idx];
  assign w_last     = (r_idx == LAST_IDX);
  assign w_tmo_exp  = (r_tmo == TMO_LAST);
  // Count including the sensor sampled at this edge, so the empty-mask decision is made on the last read.
  assign w_cnt_scan = w_hit ? r_cnt + 8'd1 : r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    div_start_o = 1'b0;
    busy_o      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_last) begin
          if (w_cnt_scan == 8'd0) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_DIV_REQ;
          end
        end
      end
      ST_DIV_REQ: begin
        div_start_o = 1'b1;
        w_state_nxt = ST_DIV_WAIT;
      end
      ST_DIV_WAIT: begin
        if (div_done_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tmo_exp) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mask  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_tmo   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_nr    <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_mask  <= sensor_en_i;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (w_hit) begin
            r_sum <= r_sum + {8'd0, sensor_data_i};
            r_cnt <= r_cnt + 8'd1;
          end
          r_idx <= w_last ? '0 : r_idx + 3'd1;
        end
        ST_DIV_REQ: r_tmo <= '0;
        ST_DIV_WAIT: begin
          if (div_done_i) begin
            r_q     <= div_q_i;
            r_r     <= div_r_i;
            r_nr    <= r_cnt;
            r_valid <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sensor_sel_o        = r_idx;
  assign div_dividend_o      = r_sum;
  assign div_divisor_o       = r_cnt;
  assign temp_Q_o            = r_q;
  assign temp_R_o            = r_r;
  assign active_sensors_nr_o = r_nr;
  assign result_valid_o      = r_valid;
  assign err_o               = r_err;

endmodule

// File: tb/tb_temp_acq_ctrl.sv
// Directed plus randomized bench for temp_acq_ctrl; expected sums, counts and
// averages come from an arithmetic model of the sensor bank and divider.
module tb_temp_acq_ctrl;
  localparam int N   = 8;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  sensor_en_i;
  logic [2:0]  sensor_sel_o;
  logic [7:0]  sensor_data_i;
  logic        div_start_o;
  logic [15:0] div_dividend_o;
  logic [7:0]  div_divisor_o;
  logic        div_done_i;
  logic [15:0] div_q_i;
  logic [15:0] div_r_i;
  logic [15:0] temp_Q_o;
  logic [15:0] temp_R_o;
  logic [7:0]  active_sensors_nr_o;
  logic        result_valid_o;
  logic        busy_o;
  logic        err_o;

  logic [7:0]  data_arr [N];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_Q  = '0;
  logic [15:0] exp_R  = '0;
  logic [7:0]  exp_nr = '0;

  always #5 clk = ~clk;

  // Sensor bank: the selected sensor's reading is valid in the same cycle.
  always_comb sensor_data_i = data_arr[sensor_sel_o];

  temp_acq_ctrl #(
    .SENSOR_NR  (N),
    .DIV_TIMEOUT(TMO)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .start_i            (start_i),
    .sensor_en_i        (sensor_en_i),
    .sensor_sel_o       (sensor_sel_o),
    .sensor_data_i      (sensor_data_i),
    .div_start_o        (div_start_o),
    .div_dividend_o     (div_dividend_o),
    .div_divisor_o      (div_divisor_o),
    .div_done_i         (div_done_i),
    .div_q_i            (div_q_i),
    .div_r_i            (div_r_i),
    .temp_Q_o           (temp_Q_o),
    .temp_R_o           (temp_R_o),
    .active_sensors_nr_o(active_sensors_nr_o),
    .result_valid_o     (result_valid_o),
    .busy_o             (busy_o),
    .err_o              (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_Q"},  temp_Q_o, exp_Q);
    chk({tag, "_R"},  temp_R_o, exp_R);
    chk({tag, "_nr"}, active_sensors_nr_o, exp_nr);
  endtask

  // One measurement cycle. dly = cycles from div_start to done (0: divider never answers).
  task automatic run_meas(input logic [7:0] mask, input int dly, input bit noise);
    int unsigned esum;
    int unsigned ecnt;
    esum = 0;
    ecnt = 0;
    for (int k = 0; k < N; k++)
      if (mask[k]) begin
        esum += data_arr[k];
        ecnt++;
      end
    sensor_en_i = mask;
    start_i     = 1'b1;
    @(negedge clk);
    chk("start_busy", busy_o, 1);
    chk("start_valid_cleared", result_valid_o, 0);
    if (!noise) start_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("scan_sel", sensor_sel_o, k);
      chk("scan_no_div_start", div_start_o, 0);
      chk("scan_busy", busy_o, 1);
      if (noise) begin
        if (k == 3) sensor_en_i = ~mask;
        div_done_i = (k == 2);
      end
      @(negedge clk);
    end
    div_done_i  = 1'b0;
    start_i     = 1'b0;
    sensor_en_i = mask;
    if (ecnt == 0) begin
      chk("nosens_err", err_o, 1);
      chk("nosens_busy", busy_o, 0);
      chk("nosens_div_start", div_start_o, 0);
      chk("nosens_valid", result_valid_o, 0);
      check_held("nosens_hold");
      @(negedge clk);
      chk("nosens_err_end", err_o, 0);
      chk("nosens_div_start2", div_start_o, 0);
      return;
    end
    chk("req_div_start", div_start_o, 1);
    chk("req_dividend", div_dividend_o, esum);
    chk("req_divisor", div_divisor_o, ecnt);
    chk("req_err", err_o, 0);
    if (dly == 0) begin
      for (int i = 1; i <= TMO; i++) begin
        @(negedge clk);
        chk("wait_err", err_o, 0);
        chk("wait_busy", busy_o, 1);
        chk("wait_div_start", div_start_o, 0);
      end
      @(negedge clk);
      chk("tmo_err", err_o, 1);
      chk("tmo_busy", busy_o, 0);
      chk("tmo_valid", result_valid_o, 0);
      check_held("tmo_hold");
      @(negedge clk);
      chk("tmo_err_end", err_o, 0);
      return;
    end
    for (int i = 1; i < dly; i++) begin
      @(negedge clk);
      chk("dw_busy", busy_o, 1);
      chk("dw_div_start", div_start_o, 0);
      chk("dw_dividend", div_dividend_o, esum);
      chk("dw_divisor", div_divisor_o, ecnt);
    end
    @(negedge clk);
    div_done_i = 1'b1;
    div_q_i    = 16'(esum / ecnt);
    div_r_i    = 16'(esum % ecnt);
    chk("pre_done_valid", result_valid_o, 0);
    @(negedge clk);
    div_done_i = 1'b0;
    div_q_i    = 16'($urandom);
    div_r_i    = 16'($urandom);
    exp_Q  = 16'(esum / ecnt);
    exp_R  = 16'(esum % ecnt);
    exp_nr = 8'(ecnt);
    chk("res_valid", result_valid_o, 1);
    chk("res_busy", busy_o, 0);
    chk("res_err", err_o, 0);
    check_held("res");
  endtask

  initial begin
    rst_i       = 1'b1;
    start_i     = 1'b0;
    sensor_en_i = '0;
    div_done_i  = 1'b0;
    div_q_i     = '0;
    div_r_i     = '0;
    for (int k = 0; k < N; k++) data_arr[k] = 8'(20 + k);
    repeat (2) @(negedge clk);
    chk("rst_sel", sensor_sel_o, 0);
    chk("rst_div_start", div_start_o, 0);
    chk("rst_dividend", div_dividend_o, 0);
    chk("rst_divisor", div_divisor_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_valid", result_valid_o, 0);
    check_held("rst");
    rst_i = 1'b0;

    // Done outside DIV_WAIT must be ignored.
    div_done_i = 1'b1;
    div_q_i    = 16'd77;
    @(negedge clk);
    div_done_i = 1'b0;
    chk("idle_done_valid", result_valid_o, 0);
    check_held("idle_done");

    // All sensors active, data 20..27.
    run_meas(8'hFF, 1, 1'b0);
    chk("all_Q_const", temp_Q_o, 23);
    chk("all_R_const", temp_R_o, 4);
    chk("all_nr_const", active_sensors_nr_o, 8);

    // Partial mask 0x05.
    for (int k = 0; k < N; k++) data_arr[k] = 8'd99;
    data_arr[0] = 8'd30;
    data_arr[2] = 8'd31;
    run_meas(8'h05, 2, 1'b0);
    chk("part_Q_const", temp_Q_o, 30);
    chk("part_R_const", temp_R_o, 1);
    chk("part_nr_const", active_sensors_nr_o, 2);

    // No active sensor.
    run_meas(8'h00, 1, 1'b0);

    // Divider timeout.
    for (int k = 0; k < N; k++) data_arr[k] = 8'($urandom_range(0, 255));
    run_meas(8'(($urandom & 32'hFE) | 32'h01), 0, 1'b0);

    // Start held, mask toggled and spurious done during the scan.
    for (int k = 0; k < N; k++) data_arr[k] = 8'($urandom_range(0, 255));
    run_meas(8'h5A, 3, 1'b1);

    // Reset while waiting on the divider.
    sensor_en_i = 8'hFF;
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (N + 1) @(negedge clk);
    chk("mid_busy", busy_o, 1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i      = 1'b0;
    div_done_i = 1'b1;
    div_q_i    = 16'd321;
    div_r_i    = 16'd5;
    exp_Q  = '0;
    exp_R  = '0;
    exp_nr = '0;
    chk("mrst_busy", busy_o, 0);
    chk("mrst_valid", result_valid_o, 0);
    chk("mrst_dividend", div_dividend_o, 0);
    chk("mrst_divisor", div_divisor_o, 0);
    chk("mrst_div_start", div_start_o, 0);
    chk("mrst_err", err_o, 0);
    check_held("mrst");
    @(negedge clk);
    div_done_i = 1'b0;
    chk("mrst_done_ignored", result_valid_o, 0);
    check_held("mrst_done");
    run_meas(8'hC3, 1, 1'b0);

    // Randomized cycles.
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < N; k++) data_arr[k] = 8'($urandom_range(0, 255));
      run_meas(8'($urandom), int'($urandom_range(1, 6)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
